// File: rtl/spi_pkg.sv
// Shared state encoding and mode-0 idle levels for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } spi_state_e;

    localparam logic SCK_IDLE = 1'b0;
    localparam logic SS_IDLE  = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// Control-side handshake plus SPI pin bundle for spi_master.
interface spi_master_if #(
    parameter int SEND_DATA_LEN = 8,
    parameter int RECV_DATA_LEN = 12
);
    logic                     start;
    logic [SEND_DATA_LEN-1:0] send_data;
    logic                     busy;
    logic [RECV_DATA_LEN-1:0] recv_data;
    logic                     recv_data_rdy;
    logic                     sck;
    logic                     ss;
    logic                     mosi;
    logic                     miso;

    modport master (
        input  start, send_data, miso,
        output busy, recv_data, recv_data_rdy, sck, ss, mosi
    );

    modport slave (
        output start, send_data, miso,
        input  busy, recv_data, recv_data_rdy, sck, ss, mosi
    );
endinterface

// File: rtl/spi_sck_gen.sv
// Half-period counter: strobes phase_end on the last clk cycle of every
// CLK_DIV-long phase while a frame is running.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end
);
    // Keep at least one counter bit so CLK_DIV=1 still elaborates.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_end = run && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = '0;
        if (run && !phase_end) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one start pulse runs one full-duplex frame of
// max(SEND_DATA_LEN, RECV_DATA_LEN) sck pulses followed by a one-phase gap.
module spi_master
    import spi_pkg::*;
#(
    parameter int SEND_DATA_LEN = 8,
    parameter int RECV_DATA_LEN = 12,
    parameter int CLK_DIV       = 4
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    localparam int N  = (SEND_DATA_LEN > RECV_DATA_LEN) ? SEND_DATA_LEN : RECV_DATA_LEN;
    localparam int BW = $clog2(N + 1);

    spi_state_e               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     sck_q, sck_d;
    logic                     ss_q, ss_d;
    logic                     mosi_q, mosi_d;
    logic                     rdy_q, rdy_d;
    logic [N-1:0]             tx_q, tx_d, tx_shift;
    logic [RECV_DATA_LEN-1:0] rx_q, rx_d;
    logic [RECV_DATA_LEN-1:0] recv_q, recv_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic                     phase_end;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst_n     (rst),
        .run       (state_q != IDLE),
        .phase_end (phase_end)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        sck_d    = sck_q;
        ss_d     = ss_q;
        mosi_d   = mosi_q;
        rdy_d    = 1'b0;
        tx_d     = tx_q;
        rx_d     = rx_q;
        recv_d   = recv_q;
        bit_d    = bit_q;
        tx_shift = tx_q << 1;
        case (state_q)
            IDLE: if (bus.start) begin
                // Left-justify so the zero padding trails the payload.
                tx_d    = N'(bus.send_data) << (N - SEND_DATA_LEN);
                mosi_d  = tx_d[N-1];
                ss_d    = ~SS_IDLE;
                sck_d   = SCK_IDLE;
                busy_d  = 1'b1;
                bit_d   = '0;
                rx_d    = '0;
                state_d = SETUP;
            end
            SETUP: if (phase_end) begin
                sck_d   = ~SCK_IDLE;
                state_d = HIGH;
            end
            HIGH: if (phase_end) begin
                sck_d   = SCK_IDLE;
                tx_d    = tx_shift;
                mosi_d  = tx_shift[N-1];
                bit_d   = bit_q + 1'b1;
                if (bit_q < BW'(RECV_DATA_LEN))
                    rx_d = (rx_q << 1) | RECV_DATA_LEN'(bus.miso);
                state_d = LOW;
            end
            LOW: if (phase_end) begin
                if (bit_q == BW'(N)) begin
                    ss_d    = SS_IDLE;
                    mosi_d  = 1'b0;
                    recv_d  = rx_q;
                    rdy_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    sck_d   = ~SCK_IDLE;
                    state_d = HIGH;
                end
            end
            GAP: if (phase_end) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sck_q   <= SCK_IDLE;
            ss_q    <= SS_IDLE;
            mosi_q  <= 1'b0;
            rdy_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            recv_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            rdy_q   <= rdy_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            recv_q  <= recv_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.sck           = sck_q;
    assign bus.ss            = ss_q;
    assign bus.mosi          = mosi_q;
    assign bus.recv_data     = recv_q;
    assign bus.recv_data_rdy = rdy_q;
endmodule
